seq_tx: RTL



---
 rtl/seq_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seq_tx.sv
// Serial bit-sequence transmitter: latches a pattern on start and shifts it out MSB-first,
// optionally repeating the frame with a one-cycle gap. Define SEQ_TX_PARITY_EN to append an even-parity bit per frame.
module seq_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SHIFT, GAP, DONE, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamp;
    logic             end_frame;
    logic             cur_bit;
`ifdef SEQ_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Bit select with a LEN_W-wide index that may exceed the pattern width.
    function automatic logic bit_at(input logic [WIDTH-1:0] v, input logic [LEN_W-1:0] i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (i == LEN_W'(k)) b = v[k];
        end
        return b;
    endfunction

    assign len_clamp = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign cur_bit   = bit_at(pat_q, idx_q);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        x_d       = 1'b0;
        xv_d      = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        end_frame = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pat_d  = pattern;
                    len_d  = len_clamp;
                    rep_d  = repeat_n;
                    busy_d = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                    par_d  = 1'b0;
`endif
                    if (len_clamp == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        idx_d   = len_clamp - LEN_W'(1);
                        x_d     = bit_at(pattern, len_clamp - LEN_W'(1));
                        xv_d    = 1'b1;
                    end
                end
            end
            SHIFT: begin
`ifdef SEQ_TX_PARITY_EN
                par_d = par_q ^ cur_bit;
`endif
                if (idx_q != '0) begin
                    idx_d = idx_q - LEN_W'(1);
                    x_d   = bit_at(pat_q, idx_q - LEN_W'(1));
                    xv_d  = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = PARITY;
                    x_d     = par_q ^ cur_bit;
                    xv_d    = 1'b1;
`else
                    end_frame = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PARITY: end_frame = 1'b1;
`endif
            GAP: begin
                if (rep_q != '0) rep_d = rep_q - CNT_W'(1);
                idx_d   = len_q - LEN_W'(1);
                state_d = SHIFT;
                x_d     = bit_at(pat_q, len_q - LEN_W'(1));
                xv_d    = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                par_d   = 1'b0;
`endif
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (end_frame) begin
            if (rep_q != '0) begin
                state_d = GAP;
            end else begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
